// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS control FSM (define MIPS_CTRL_JUMP_EN to decode j)
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       write_enable,
    output logic       write_memory,
    output logic       read_memory,
    output logic       branch,
    output logic [1:0] aluop,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        WB_MEM    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        WB_R      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t state_q, state_d;
    logic   run_q;
    logic   legal;

`ifdef MIPS_CTRL_JUMP_EN
    assign legal = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
`else
    assign legal = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ};
`endif

    // next-state selection; run_q holds IDLE one extra cycle after reset release
    always_comb begin
        state_d = FETCH;
        case (state_q)
            IDLE:      state_d = run_q ? FETCH : IDLE;
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE:    state_d = opcode == OP_R ? EXEC_R :
                                 (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                                 opcode == OP_BEQ ? BRANCH :
`ifdef MIPS_CTRL_JUMP_EN
                                 opcode == OP_J ? JUMP :
`endif
                                 FETCH;
            MEM_ADDR:  state_d = opcode == OP_LW ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_d = mem_ready ? WB_MEM : MEM_READ;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            EXEC_R:    state_d = WB_R;
            default:   state_d = FETCH;
        endcase
    end

    // state register with asynchronous reset to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Moore output decode; only FETCH strobes and the DECODE illegal flag see inputs
    always_comb begin
        write_enable = 1'b0;
        write_memory = 1'b0;
        read_memory  = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        illegal_op   = 1'b0;
        case (state_q)
            FETCH: begin
                read_memory = 1'b1;
                alu_src_b   = 2'b01;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !legal;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_READ: begin
                read_memory = 1'b1;
                iord        = 1'b1;
            end
            WB_MEM: begin
                write_enable = 1'b1;
                mem_to_reg   = 1'b1;
            end
            MEM_WRITE: begin
                write_memory = 1'b1;
                iord         = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
            end
            WB_R: begin
                write_enable = 1'b1;
                reg_dst      = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
`ifdef MIPS_CTRL_JUMP_EN
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed scoreboard bench for the multi-cycle control FSM
module tb_mips_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       write_enable, write_memory, read_memory, branch;
    logic [1:0] aluop;
    logic       pc_write, ir_write, iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       illegal_op;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .write_enable(write_enable), .write_memory(write_memory), .read_memory(read_memory),
        .branch(branch), .aluop(aluop), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input logic [3:0] st, input logic we, wm, rm, br,
                                       input logic [1:0] aop, input logic pcw, irw, io, m2r, rd, sa,
                                       input logic [1:0] sb, ps, input logic il);
        return {st, we, wm, rm, br, aop, pcw, irw, io, m2r, rd, sa, sb, ps, il};
    endfunction

    //                          st     we    wm    rm    br    aop    pcw   irw   io    m2r   rd    sa    sb     ps     il
    localparam logic [20:0] E_IDLE  = mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] E_FETCH = mk(4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    localparam logic [20:0] E_FWAIT = mk(4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    localparam logic [20:0] E_DEC   = mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
    localparam logic [20:0] E_DILL  = mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1);
    localparam logic [20:0] E_MADR  = mk(4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
    localparam logic [20:0] E_MRD   = mk(4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] E_WBM   = mk(4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] E_MWR   = mk(4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] E_EXR   = mk(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] E_WBR   = mk(4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] E_BR    = mk(4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
    localparam logic [20:0] E_JMP   = mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);

    logic [20:0] obs;
    assign obs = {state, write_enable, write_memory, read_memory, branch, aluop, pc_write, ir_write,
                  iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src, illegal_op};

    logic [20:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // pop the oldest expectation and compare it with the live outputs
    task automatic chk(input string tag);
        logic [20:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // one clock cycle: drive inputs, record expectation, sample at negedge
    task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input logic [20:0] e);
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back(e);
        @(negedge clk);
        chk(tag);
        @(posedge clk);
        #1;
    endtask

    // release reset just after an edge and check the two IDLE cycles before FETCH
    task automatic release_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc({tag, "_idle0"}, 6'b000000, 1'b1, E_IDLE);
        cyc({tag, "_idle1"}, 6'b000000, 1'b1, E_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        #12;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E_IDLE);
        chk("reset_async");
        release_reset("rst");

        cyc("r_fetch",  6'b000000, 1'b1, E_FETCH);
        cyc("r_decode", 6'b000000, 1'b1, E_DEC);
        cyc("r_exec",   6'b000000, 1'b1, E_EXR);
        cyc("r_wb",     6'b000000, 1'b1, E_WBR);

        cyc("lw_fwait", 6'b100011, 1'b0, E_FWAIT);
        cyc("lw_fetch", 6'b100011, 1'b1, E_FETCH);
        cyc("lw_dec",   6'b100011, 1'b1, E_DEC);
        cyc("lw_addr",  6'b100011, 1'b1, E_MADR);
        cyc("lw_rd0",   6'b100011, 1'b0, E_MRD);
        cyc("lw_rd1",   6'b100011, 1'b0, E_MRD);
        cyc("lw_rd2",   6'b100011, 1'b1, E_MRD);
        cyc("lw_wb",    6'b100011, 1'b1, E_WBM);

        cyc("sw_fetch", 6'b101011, 1'b1, E_FETCH);
        cyc("sw_dec",   6'b101011, 1'b1, E_DEC);
        cyc("sw_addr",  6'b101011, 1'b1, E_MADR);
        cyc("sw_wr0",   6'b101011, 1'b0, E_MWR);
        cyc("sw_wr1",   6'b101011, 1'b1, E_MWR);

        cyc("beq_fetch", 6'b000100, 1'b1, E_FETCH);
        cyc("beq_dec",   6'b000100, 1'b1, E_DEC);
        cyc("beq_br",    6'b000100, 1'b1, E_BR);

        cyc("ill_fetch", 6'b111111, 1'b1, E_FETCH);
        cyc("ill_dec",   6'b111111, 1'b1, E_DILL);
        cyc("ill2_fetch", 6'b000011, 1'b1, E_FETCH);
        cyc("ill2_dec",   6'b000011, 1'b0, E_DILL);

        cyc("j_fetch", 6'b000010, 1'b1, E_FETCH);
`ifdef MIPS_CTRL_JUMP_EN
        cyc("j_dec",   6'b000010, 1'b1, E_DEC);
        cyc("j_jump",  6'b000010, 1'b1, E_JMP);
`else
        cyc("j_dec",   6'b000010, 1'b1, E_DILL);
`endif
        cyc("after_fetch", 6'b101011, 1'b1, E_FETCH);
        cyc("rw_dec",   6'b101011, 1'b1, E_DEC);
        cyc("rw_addr",  6'b101011, 1'b1, E_MADR);
        cyc("rw_hold",  6'b101011, 1'b0, E_MWR);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E_IDLE);
        chk("rw_abort");
        release_reset("rw");
        cyc("rw_refetch", 6'b000000, 1'b1, E_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
